// File: rtl/processador_pkg.sv
// Shared fetch-unit types: the fetch FSM state encoding and the default
// reset/halt instruction words.
package processador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    FULL    = 2'd2,
    STOPPED = 2'd3
  } fetch_state_t;

  localparam int                           DEFAULT_DATA_WIDTH = 32;
  localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_NOP_WORD   = '0;
  localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_HALT_WORD  = '1;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: one memory read per PC value over a req/ack handshake,
// registered hand-off to decode, and the halt/advance control for the PC.
module instruction_fetch
  import processador_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = DATA_WIDTH'(DEFAULT_NOP_WORD),
  parameter logic [DATA_WIDTH-1:0] HALT_WORD   = DATA_WIDTH'(DEFAULT_HALT_WORD),
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   jump_taken,
  output logic                   fetch_halt,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [DATA_WIDTH-1:0]  instruction,
  output logic                   instruction_valid,
  input  logic                   decode_stall,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  fetch_state_t          state, state_next;
  logic                  drop, drop_next;
  logic [DATA_WIDTH-1:0] skid;
  logic                  slot_free;
  logic                  squash;
  logic                  issue;
  logic                  accept;
  logic                  capture_skid;
  logic [DATA_WIDTH-1:0] accept_word;

  assign slot_free = !instruction_valid || !decode_stall;

  always_comb begin
    state_next   = state;
    drop_next    = drop;
    issue        = 1'b0;
    accept       = 1'b0;
    capture_skid = 1'b0;
    accept_word  = skid;
    // Once stopped, jumps no longer redirect the PC or squash the slot.
    squash       = jump_taken && (state != STOPPED);
    case (state)
      IDLE: begin
        if (slot_free && !jump_taken) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (drop || jump_taken) begin
            drop_next  = 1'b0;
            state_next = IDLE;
          end else if (slot_free) begin
            accept      = 1'b1;
            accept_word = mem_rdata;
            state_next  = (mem_rdata == HALT_WORD) ? STOPPED : IDLE;
          end else begin
            capture_skid = 1'b1;
            state_next   = FULL;
          end
        end else if (jump_taken) begin
          drop_next = 1'b1;
        end
      end
      FULL: begin
        if (jump_taken) begin
          state_next = IDLE;
        end else if (!decode_stall) begin
          accept      = 1'b1;
          accept_word = skid;
          state_next  = (skid == HALT_WORD) ? STOPPED : IDLE;
        end
      end
      STOPPED: ;
      default: state_next = IDLE;
    endcase
    fetch_halt = !(accept || squash);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      drop              <= 1'b0;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      instruction       <= NOP_WORD;
      instruction_valid <= 1'b0;
      fetch_count       <= '0;
    end else begin
      state   <= state_next;
      drop    <= drop_next;
      mem_req <= issue;
      if (issue) begin
        mem_addr <= pc;
      end
      // A jump beats both a new capture and normal consumption.
      if (squash) begin
        instruction_valid <= 1'b0;
      end else if (accept) begin
        instruction       <= accept_word;
        instruction_valid <= 1'b1;
      end else if (!decode_stall) begin
        instruction_valid <= 1'b0;
      end
      if (accept) begin
        fetch_count <= fetch_count + COUNT_WIDTH'(1);
      end
    end
  end

  // Skid entry holds a returned word while decode is stalled on the previous one.
  always_ff @(posedge clock) begin
    if (capture_skid) begin
      skid <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural PC and a latency-programmable
// instruction memory surround the fetch unit; each task checks one scenario.
module tb_instruction_fetch;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc;
  logic        jump_taken;
  logic        fetch_halt;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        decode_stall;
  logic [3:0]  fetch_count;

  instruction_fetch #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NOP_WORD   (32'h0000_0000),
    .HALT_WORD  (32'hFFFF_FFFF),
    .COUNT_WIDTH(4)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pc               (pc),
    .jump_taken       (jump_taken),
    .fetch_halt       (fetch_halt),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .instruction      (instruction),
    .instruction_valid(instruction_valid),
    .decode_stall     (decode_stall),
    .fetch_count      (fetch_count)
  );

  int          vectors;
  int          miscompares;
  logic [31:0] mem [0:255];
  int          mem_lat;
  int          mem_cnt;
  logic [31:0] jump_target;
  logic [31:0] got [$];
  logic [3:0]  prev_count;
  int          req_count;
  int          halt_lows;
  logic        fh_s;
  logic        jt_s;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: ack arrives mem_lat cycles after the request cycle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_cnt   = 0;
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (!reset_n) begin
        mem_cnt = 0;
      end else begin
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[7:0]];
          end
        end
        if (mem_req) mem_cnt = mem_lat;
      end
    end
  end

  // Program counter model plus delivery / request / halt-low monitors.
  initial begin
    pc         = '0;
    prev_count = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_count = '0;
      end else begin
        if (fetch_count !== prev_count) begin
          got.push_back(instruction);
          prev_count = fetch_count;
        end
        if (mem_req) req_count++;
      end
      #3;
      fh_s = fetch_halt;
      jt_s = jump_taken;
      if (reset_n && !fh_s) halt_lows++;
      @(posedge clock);
      #1;
      if (!reset_n) pc = '0;
      else if (!fh_s) pc = jt_s ? jump_target : pc + 32'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    jump_taken   = 1'b0;
    decode_stall = 1'b0;
    step();
    step();
    got.delete();
    req_count = 0;
    halt_lows = 0;
    mem_lat   = 1;
    reset_n   = 1'b1;
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    vectors++;
    if (got.size() < n) begin
      miscompares++;
      $display("FAIL wait_fetches delivered=%0d required=%0d", got.size(), n);
    end
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    int k;
    k = 0;
    while (mem_req !== 1'b1 && k < 12) begin
      step();
      k++;
    end
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL %s req=%b addr=%h required req=1 addr=%h", name, mem_req, mem_addr, exp_addr);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    jump_taken   = 1'b0;
    decode_stall = 1'b0;
    step();
    step();
    vectors++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mem req=%b addr=%h required 0/0", mem_req, mem_addr);
    end
    vectors++;
    if (instruction !== 32'h0 || instruction_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_instr instr=%h valid=%b required 0/0", instruction, instruction_valid);
    end
    vectors++;
    if (fetch_count !== 4'd0 || fetch_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ctrl count=%0d halt=%b required 0/1", fetch_count, fetch_halt);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    apply_reset();
    wait_fetches(3, 40);
    vectors++;
    if (got.size() != 3 || got[0] !== 32'h11 || got[1] !== 32'h22 || got[2] !== 32'h33) begin
      miscompares++;
      $display("FAIL basic_seq n=%0d w0=%h w1=%h w2=%h required 11 22 33", got.size(),
               (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx,
               (got.size() > 2) ? got[2] : 32'hx);
    end
    vectors++;
    if (fetch_count !== 4'd3 || halt_lows != 3 || pc !== 32'd3) begin
      miscompares++;
      $display("FAIL basic_pc count=%0d halt_lows=%0d pc=%h required 3 3 3", fetch_count, halt_lows, pc);
    end
  endtask

  task automatic test_stall();
    int snap;
    int bad;
    apply_reset();
    wait_fetches(1, 20);
    decode_stall = 1'b1;
    snap = req_count;
    bad  = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      if (fetch_halt !== 1'b1 || instruction !== 32'h11 || instruction_valid !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0 || req_count != snap) begin
      miscompares++;
      $display("FAIL stall_hold bad_cycles=%0d reqs=%0d required 0 and %0d", bad, req_count, snap);
    end
    decode_stall = 1'b0;
    wait_fetches(3, 40);
    vectors++;
    if (got.size() != 3 || got[1] !== 32'h22 || got[2] !== 32'h33 || pc !== 32'd3) begin
      miscompares++;
      $display("FAIL stall_release n=%0d pc=%h required n=3 pc=3 words 22 33", got.size(), pc);
    end
  endtask

  task automatic test_jump_wait();
    apply_reset();
    wait_fetches(5, 60);
    mem_lat     = 2;
    jump_target = 32'h40;
    wait_req("jw_req5", 32'd5);
    jump_taken = 1'b1;
    #1;
    vectors++;
    if (fetch_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL jw_halt got=%b required 0", fetch_halt);
    end
    step();
    jump_taken = 1'b0;
    step();
    #1;
    vectors++;
    if (mem_ack !== 1'b1 || fetch_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL jw_drop ack=%b halt=%b required 1/1", mem_ack, fetch_halt);
    end
    wait_req("jw_req40", 32'h40);
    vectors++;
    if (fetch_count !== 4'd5 || got.size() != 5 || pc !== 32'h40) begin
      miscompares++;
      $display("FAIL jw_after count=%0d n=%0d pc=%h required 5 5 40", fetch_count, got.size(), pc);
    end
  endtask

  task automatic test_jump_ack();
    int k;
    apply_reset();
    wait_fetches(1, 20);
    mem_lat     = 2;
    jump_target = 32'h20;
    k = 0;
    while (mem_ack !== 1'b1 && k < 12) begin
      step();
      k++;
    end
    jump_taken = 1'b1;
    #1;
    vectors++;
    if (mem_ack !== 1'b1 || fetch_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL ja_halt ack=%b halt=%b required 1/0", mem_ack, fetch_halt);
    end
    step();
    jump_taken = 1'b0;
    vectors++;
    if (instruction_valid !== 1'b0 || fetch_count !== 4'd1 || pc !== 32'h20) begin
      miscompares++;
      $display("FAIL ja_discard valid=%b count=%0d pc=%h required 0 1 20", instruction_valid, fetch_count, pc);
    end
    wait_req("ja_req20", 32'h20);
  endtask

  task automatic test_halt_word();
    int snap;
    mem[1] = 32'hFFFF_FFFF;
    apply_reset();
    wait_fetches(2, 20);
    vectors++;
    if (instruction !== 32'hFFFF_FFFF || instruction_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_word instr=%h valid=%b required ffffffff/1", instruction, instruction_valid);
    end
    snap = req_count;
    step();
    step();
    jump_target = 32'h40;
    jump_taken  = 1'b1;
    #1;
    vectors++;
    if (fetch_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_jump halt=%b required 1", fetch_halt);
    end
    step();
    jump_taken = 1'b0;
    for (int i = 0; i < 6; i++) step();
    vectors++;
    if (req_count != snap || pc !== 32'd2 || fetch_count !== 4'd2 || instruction_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_stop reqs=%0d pc=%h count=%0d valid=%b required %0d 2 2 0",
               req_count, pc, fetch_count, instruction_valid, snap);
    end
    mem[1] = 32'h22;
  endtask

  task automatic test_wrap_and_async_reset();
    apply_reset();
    wait_fetches(17, 120);
    vectors++;
    if (fetch_count !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_count got=%0d required 1", fetch_count);
    end
    wait_req("wrap_req17", 32'd17);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instruction !== 32'h0 ||
        instruction_valid !== 1'b0 || fetch_count !== 4'd0 || fetch_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL async_rst req=%b addr=%h instr=%h valid=%b count=%0d halt=%b required 0 0 0 0 0 1",
               mem_req, mem_addr, instruction, instruction_valid, fetch_count, fetch_halt);
    end
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    req_count    = 0;
    halt_lows    = 0;
    mem_lat      = 1;
    jump_target  = '0;
    reset_n      = 1'b0;
    jump_taken   = 1'b0;
    decode_stall = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;

    test_reset();
    test_basic();
    test_stall();
    test_jump_wait();
    test_jump_ack();
    test_halt_word();
    test_wrap_and_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
